// File: rtl/mem_axi_mux.sv
// N-port AXI4 slave mux onto a single host mem interface, one burst in flight at a time.
// Define MEM_AXI_MUX_FIXED_PRIO_EN for fixed priority (lowest port wins); default is round-robin.
module mem_axi_mux #(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned MEM_LEN_BITS  = 8,
    parameter int unsigned MEM_ADDR_BITS = 32,
    parameter int unsigned MEM_DATA_BITS = 64,
    parameter int unsigned AXI_ID_BITS   = 1,
    parameter int unsigned WR_TIMEOUT    = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0]               s_axi_awvalid,
    output logic [NUM_PORTS-1:0]               s_axi_awready,
    input  logic [NUM_PORTS*MEM_ADDR_BITS-1:0] s_axi_awaddr,
    input  logic [NUM_PORTS*8-1:0]             s_axi_awlen,
    input  logic [NUM_PORTS*AXI_ID_BITS-1:0]   s_axi_awid,
    input  logic [NUM_PORTS-1:0]               s_axi_wvalid,
    output logic [NUM_PORTS-1:0]               s_axi_wready,
    input  logic [NUM_PORTS*MEM_DATA_BITS-1:0] s_axi_wdata,
    input  logic [NUM_PORTS-1:0]               s_axi_wlast,
    output logic [NUM_PORTS-1:0]               s_axi_bvalid,
    input  logic [NUM_PORTS-1:0]               s_axi_bready,
    output logic [NUM_PORTS*2-1:0]             s_axi_bresp,
    output logic [NUM_PORTS*AXI_ID_BITS-1:0]   s_axi_bid,
    input  logic [NUM_PORTS-1:0]               s_axi_arvalid,
    output logic [NUM_PORTS-1:0]               s_axi_arready,
    input  logic [NUM_PORTS*MEM_ADDR_BITS-1:0] s_axi_araddr,
    input  logic [NUM_PORTS*8-1:0]             s_axi_arlen,
    input  logic [NUM_PORTS*AXI_ID_BITS-1:0]   s_axi_arid,
    output logic [NUM_PORTS-1:0]               s_axi_rvalid,
    input  logic [NUM_PORTS-1:0]               s_axi_rready,
    output logic [NUM_PORTS*MEM_DATA_BITS-1:0] s_axi_rdata,
    output logic [NUM_PORTS-1:0]               s_axi_rlast,
    output logic [NUM_PORTS*2-1:0]             s_axi_rresp,
    output logic [NUM_PORTS*AXI_ID_BITS-1:0]   s_axi_rid,
    output logic                               mem_req_valid,
    output logic                               mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]            mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]           mem_req_addr,
    output logic                               mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]           mem_wr_bits,
    input  logic                               mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]           mem_rd_bits,
    output logic                               mem_rd_ready
);

    localparam int unsigned SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned TMO_W = $clog2(WR_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WR_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReadData, StWriteData, StWriteAck} state_e;

    state_e                   r_state, w_state_next;
    logic [SEL_W-1:0]         r_sel, r_rr, w_gnt;
    logic [SEL_W:0]           w_idx;
    logic                     w_gnt_valid, w_gnt_rd;
    logic [NUM_PORTS-1:0]     w_req;
    logic [7:0]               r_beat, w_len;
    logic [AXI_ID_BITS-1:0]   r_id, w_id;
    logic                     r_err;
    logic [TMO_W-1:0]         r_tmo;
    logic                     w_rd_beat, w_wr_beat, w_wr_done;

    // Arbitration; no grant while in reset so a request is never half-accepted.
    always_comb begin
        w_req       = s_axi_arvalid | s_axi_awvalid;
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        w_idx       = '0;
`ifdef MEM_AXI_MUX_FIXED_PRIO_EN
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_gnt       = SEL_W'(i);
                w_gnt_valid = 1'b1;
            end
        end
`else
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = {1'b0, r_rr} + (SEL_W + 1)'(i);
            if (w_idx >= (SEL_W + 1)'(NUM_PORTS)) w_idx = w_idx - (SEL_W + 1)'(NUM_PORTS);
            if (!w_gnt_valid && w_req[w_idx[SEL_W-1:0]]) begin
                w_gnt       = w_idx[SEL_W-1:0];
                w_gnt_valid = 1'b1;
            end
        end
`endif
        if (reset || r_state != StIdle) w_gnt_valid = 1'b0;
    end

    always_comb begin
        s_axi_awready  = '0;
        s_axi_arready  = '0;
        s_axi_wready   = '0;
        s_axi_bvalid   = '0;
        s_axi_bresp    = '0;
        s_axi_bid      = '0;
        s_axi_rvalid   = '0;
        s_axi_rdata    = '0;
        s_axi_rlast    = '0;
        s_axi_rresp    = '0;
        s_axi_rid      = '0;
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;
        w_rd_beat      = 1'b0;
        w_wr_beat      = 1'b0;
        w_wr_done      = 1'b0;
        w_state_next   = r_state;

        w_gnt_rd = s_axi_arvalid[w_gnt];
        w_len    = w_gnt_rd ? s_axi_arlen[w_gnt*8 +: 8] : s_axi_awlen[w_gnt*8 +: 8];
        w_id     = w_gnt_rd ? s_axi_arid[w_gnt*AXI_ID_BITS +: AXI_ID_BITS]
                            : s_axi_awid[w_gnt*AXI_ID_BITS +: AXI_ID_BITS];

        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid) begin
                    mem_req_valid  = 1'b1;
                    mem_req_opcode = !w_gnt_rd;
                    mem_req_len    = MEM_LEN_BITS'(w_len);
                    if (w_gnt_rd) begin
                        mem_req_addr         = s_axi_araddr[w_gnt*MEM_ADDR_BITS +: MEM_ADDR_BITS];
                        s_axi_arready[w_gnt] = 1'b1;
                        w_state_next         = StReadData;
                    end else begin
                        mem_req_addr         = s_axi_awaddr[w_gnt*MEM_ADDR_BITS +: MEM_ADDR_BITS];
                        s_axi_awready[w_gnt] = 1'b1;
                        w_state_next         = StWriteData;
                    end
                end
            end
            StReadData: begin
                s_axi_rvalid[r_sel]                              = mem_rd_valid;
                s_axi_rdata[r_sel*MEM_DATA_BITS +: MEM_DATA_BITS] = mem_rd_bits;
                s_axi_rlast[r_sel]                               = (r_beat == 8'd0);
                s_axi_rid[r_sel*AXI_ID_BITS +: AXI_ID_BITS]       = r_id;
                mem_rd_ready = s_axi_rready[r_sel];
                w_rd_beat    = mem_rd_valid && s_axi_rready[r_sel];
                if (w_rd_beat && r_beat == 8'd0) w_state_next = StIdle;
            end
            StWriteData: begin
                s_axi_wready[r_sel] = 1'b1;
                mem_wr_valid        = s_axi_wvalid[r_sel];
                mem_wr_bits         = s_axi_wdata[r_sel*MEM_DATA_BITS +: MEM_DATA_BITS];
                w_wr_beat           = s_axi_wvalid[r_sel];
                // Burst ends on WLAST or on the last counted beat, whichever comes first.
                w_wr_done = w_wr_beat && (s_axi_wlast[r_sel] || r_beat == 8'd0);
                if (w_wr_done) w_state_next = StWriteAck;
                else if (!w_wr_beat && r_tmo == TMO_LAST) w_state_next = StIdle;
            end
            StWriteAck: begin
                s_axi_bvalid[r_sel]                         = 1'b1;
                s_axi_bresp[r_sel*2 +: 2]                   = r_err ? 2'b10 : 2'b00;
                s_axi_bid[r_sel*AXI_ID_BITS +: AXI_ID_BITS] = r_id;
                if (s_axi_bready[r_sel]) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel  <= '0;
            r_rr   <= '0;
            r_beat <= '0;
            r_id   <= '0;
            r_err  <= 1'b0;
            r_tmo  <= '0;
        end else begin
            if (w_gnt_valid) begin
                r_sel  <= w_gnt;
`ifdef MEM_AXI_MUX_FIXED_PRIO_EN
                r_rr   <= '0;
`else
                r_rr   <= (w_gnt == SEL_W'(NUM_PORTS - 1)) ? '0 : w_gnt + SEL_W'(1);
`endif
                r_beat <= w_len;
                r_id   <= w_id;
                r_err  <= 1'b0;
                r_tmo  <= '0;
            end
            if (w_rd_beat && r_beat != 8'd0) r_beat <= r_beat - 8'd1;
            if (r_state == StWriteData) begin
                if (w_wr_beat) begin
                    r_tmo <= '0;
                    if (w_wr_done) r_err <= s_axi_wlast[r_sel] != (r_beat == 8'd0);
                    else           r_beat <= r_beat - 8'd1;
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
            end
        end
    end

endmodule
